vram_console_ctrl: RTL and testbench

//  Text-console writer for the 60x17 character VRAM scanned by the LCD text renderer (read port B).

---
 rtl/console_pkg.sv | 31 +++
 rtl/console_cursor.sv | 64 ++++++
 rtl/vram_console_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_vram_console_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
`default_nettype none
// ==================================================================
// Package : console_pkg
// Purpose : shared console geometry, control codes and FSM states
// Rev     : 1.0
// ==================================================================
package console_pkg;

   // Screen geometry shared with the LCD text renderer (60-column stride)
   localparam int CONS_COLS = 60;
   localparam int CONS_ROWS = 17;
   localparam int COL_W     = 6;
   localparam int ROW_W     = 5;

   localparam logic [7:0] CHAR_CR    = 8'h0D;
   localparam logic [7:0] CHAR_LF    = 8'h0A;
   localparam logic [7:0] CHAR_BS    = 8'h08;
   localparam logic [7:0] CHAR_FF    = 8'h0C;
   localparam logic [7:0] BLANK_CHAR = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PUT      = 3'd1,
      ST_CLEAR    = 3'd2,
      ST_SCR_RD   = 3'd3,
      ST_SCR_WR   = 3'd4,
      ST_SCR_FILL = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/console_cursor.sv
`default_nettype none
// ==================================================================
// Module  : console_cursor
// Purpose : column/row cursor counters with inc, dec, CR, LF and home
// Rev     : 1.0
// ==================================================================
module console_cursor
   import console_pkg::*;
#(
   parameter int COLS = CONS_COLS,
   parameter int ROWS = CONS_ROWS
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             home_i,
   input  logic             cr_i,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             lf_i,
   output logic [COL_W-1:0] col_o,
   output logic [ROW_W-1:0] row_o,
   output logic             last_col_o,
   output logic             last_row_o
);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;

   assign last_col_o = (col_q == COL_W'(COLS - 1));
   assign last_row_o = (row_q == ROW_W'(ROWS - 1));
   assign col_o      = col_q;
   assign row_o      = row_q;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (home_i) begin
         col_d = '0;
         row_d = '0;
      end else begin
         if (cr_i)
            col_d = '0;
         else if (inc_i)
            col_d = col_q + 1'b1;
         else if (dec_i)
            col_d = col_q - 1'b1;
         // LF on the last row leaves the row alone; the caller scrolls instead
         if (lf_i && !last_row_o)
            row_d = row_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vram_console_ctrl.sv
`default_nettype none
// ==================================================================
// Module  : vram_console_ctrl
// Purpose : byte-stream text console writer owning VRAM port A
// Rev     : 1.0
// ==================================================================
module vram_console_ctrl
   import console_pkg::*;
#(
   parameter int         COLS       = CONS_COLS,
   parameter int         ROWS       = CONS_ROWS,
   parameter int         ADDR_W     = 10,
   parameter logic [7:0] BLANK      = BLANK_CHAR,
   parameter bit         INIT_CLEAR = 1'b1
) (
   input  logic              PixelClk,
   input  logic              nRST,
   input  logic              ch_valid,
   input  logic [7:0]        ch_data,
   output logic              ch_ready,
   input  logic              clr_req,
   output logic              busy,
   output logic [5:0]        cursor_col,
   output logic [4:0]        cursor_row,
   output logic [ADDR_W-1:0] v_ada,
   output logic [7:0]        v_dina,
   output logic              v_cea,
   output logic              v_wrea,
   input  logic [7:0]        v_douta
);

   localparam logic [ADDR_W-1:0] C_COLS_A    = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] C_LAST_CELL = ADDR_W'(COLS * ROWS - 1);
   localparam logic [ADDR_W-1:0] C_SCR_LAST  = ADDR_W'((ROWS - 1) * COLS - 1);
   localparam logic [ADDR_W-1:0] C_FILL_BASE = ADDR_W'((ROWS - 1) * COLS);

   if (COLS * ROWS > (1 << ADDR_W)) begin : g_addr_range_check
      $error("vram_console_ctrl: COLS*ROWS exceeds the ADDR_W address space");
   end

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              clr_pend_q, clr_pend_d;
   logic [7:0]        put_data_q, put_data_d;
   logic              put_adv_q, put_adv_d;
   logic [ADDR_W-1:0] ada_hold_q;
   logic [7:0]        dina_hold_q;

   logic              cur_home, cur_cr, cur_inc, cur_dec, cur_lf;
   logic              last_col, last_row;
   logic              active;
   logic [ADDR_W-1:0] cur_addr;

   console_cursor #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_cursor (
      .clk_i      (PixelClk),
      .rst_ni     (nRST),
      .home_i     (cur_home),
      .cr_i       (cur_cr),
      .inc_i      (cur_inc),
      .dec_i      (cur_dec),
      .lf_i       (cur_lf),
      .col_o      (cursor_col),
      .row_o      (cursor_row),
      .last_col_o (last_col),
      .last_row_o (last_row)
   );

   // Outputs are gated by nRST so that they read 0 while reset is held,
   // even though the reset state itself may be CLEAR.
   assign active   = nRST && (state_q != ST_IDLE);
   assign busy     = active;
   assign v_cea    = active;
   assign v_wrea   = active && (state_q != ST_SCR_RD);
   assign ch_ready = nRST && (state_q == ST_IDLE) && !clr_req && !clr_pend_q;
   assign cur_addr = ADDR_W'(cursor_row) * C_COLS_A + ADDR_W'(cursor_col);

   always_comb begin
      v_ada  = ada_hold_q;
      v_dina = dina_hold_q;
      if (active) begin
         case (state_q)
            ST_PUT: begin
               v_ada  = cur_addr;
               v_dina = put_data_q;
            end
            ST_SCR_RD: v_ada = idx_q + C_COLS_A;
            ST_SCR_WR: begin
               v_ada  = idx_q;
               v_dina = v_douta;
            end
            default: begin
               v_ada  = idx_q;
               v_dina = BLANK;
            end
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      clr_pend_d = clr_pend_q;
      put_data_d = put_data_q;
      put_adv_d  = put_adv_q;
      cur_home   = 1'b0;
      cur_cr     = 1'b0;
      cur_inc    = 1'b0;
      cur_dec    = 1'b0;
      cur_lf     = 1'b0;

      if (clr_req && state_q != ST_IDLE)
         clr_pend_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (clr_req || clr_pend_q) begin
               state_d    = ST_CLEAR;
               idx_d      = '0;
               clr_pend_d = 1'b0;
            end else if (ch_valid) begin
               case (ch_data)
                  CHAR_CR: cur_cr = 1'b1;
                  CHAR_LF: begin
                     cur_cr = 1'b1;
                     cur_lf = 1'b1;
                     if (last_row) begin
                        state_d = ST_SCR_RD;
                        idx_d   = '0;
                     end
                  end
                  CHAR_BS: begin
                     if (cursor_col != '0) begin
                        cur_dec    = 1'b1;
                        state_d    = ST_PUT;
                        put_data_d = BLANK;
                        put_adv_d  = 1'b0;
                     end
                  end
                  CHAR_FF: begin
                     state_d = ST_CLEAR;
                     idx_d   = '0;
                  end
                  default: begin
                     state_d    = ST_PUT;
                     put_data_d = ch_data;
                     put_adv_d  = 1'b1;
                  end
               endcase
            end
         end
         ST_PUT: begin
            state_d = ST_IDLE;
            if (put_adv_q) begin
               if (last_col) begin
                  cur_cr = 1'b1;
                  cur_lf = 1'b1;
                  if (last_row) begin
                     state_d = ST_SCR_RD;
                     idx_d   = '0;
                  end
               end else begin
                  cur_inc = 1'b1;
               end
            end
         end
         ST_SCR_RD: state_d = ST_SCR_WR;
         ST_SCR_WR: begin
            if (idx_q == C_SCR_LAST) begin
               state_d = ST_SCR_FILL;
               idx_d   = C_FILL_BASE;
            end else begin
               state_d = ST_SCR_RD;
               idx_d   = idx_q + 1'b1;
            end
         end
         ST_SCR_FILL: begin
            if (idx_q == C_LAST_CELL)
               state_d = ST_IDLE;
            else
               idx_d = idx_q + 1'b1;
         end
         ST_CLEAR: begin
            // any clear requested while clearing is already satisfied
            clr_pend_d = 1'b0;
            if (idx_q == C_LAST_CELL) begin
               state_d  = ST_IDLE;
               cur_home = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         state_q     <= INIT_CLEAR ? ST_CLEAR : ST_IDLE;
         idx_q       <= '0;
         clr_pend_q  <= 1'b0;
         put_data_q  <= '0;
         put_adv_q   <= 1'b0;
         ada_hold_q  <= '0;
         dina_hold_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         clr_pend_q  <= clr_pend_d;
         put_data_q  <= put_data_d;
         put_adv_q   <= put_adv_d;
         ada_hold_q  <= v_ada;
         dina_hold_q <= v_dina;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vram_console_ctrl.sv
`default_nettype none
// ==================================================================
// Module  : tb_vram_console_ctrl
// Purpose : scoreboard bench for vram_console_ctrl with a port-A RAM model
// Rev     : 1.0
// ==================================================================
module tb_vram_console_ctrl;

   localparam int COLS  = 60;
   localparam int ROWS  = 17;
   localparam int CELLS = COLS * ROWS;
   localparam int BOUND = 6000;

   logic       PixelClk = 1'b0;
   logic       nRST     = 1'b1;
   logic       ch_valid = 1'b0;
   logic [7:0] ch_data  = 8'h00;
   logic       clr_req  = 1'b0;
   logic       ch_ready, busy, v_cea, v_wrea;
   logic [5:0] cursor_col;
   logic [4:0] cursor_row;
   logic [9:0] v_ada;
   logic [7:0] v_dina, v_douta;

   logic [7:0] mem     [0:1023];
   logic [7:0] exp_img [0:1023];
   logic       pre_load = 1'b0;

   typedef struct packed {
      logic [9:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t sb[$];
   wr_t mon_e;
   int  errors = 0;
   int  checks = 0;

   always #5 PixelClk = ~PixelClk;

   vram_console_ctrl dut (
      .PixelClk   (PixelClk),
      .nRST       (nRST),
      .ch_valid   (ch_valid),
      .ch_data    (ch_data),
      .ch_ready   (ch_ready),
      .clr_req    (clr_req),
      .busy       (busy),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .v_ada      (v_ada),
      .v_dina     (v_dina),
      .v_cea      (v_cea),
      .v_wrea     (v_wrea),
      .v_douta    (v_douta)
   );

   // Port-A RAM: 1-cycle read latency
   always @(posedge PixelClk) begin
      if (pre_load) begin
         for (int i = 0; i < CELLS; i++) mem[i] <= 8'(8'h30 + i / COLS);
      end else if (v_cea && v_wrea) begin
         mem[v_ada] <= v_dina;
      end
      if (v_cea && !v_wrea) v_douta <= mem[v_ada];
   end

   // Every write on port A is popped against the scoreboard
   always @(negedge PixelClk) begin
      if (nRST && v_cea && v_wrea) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL vram_write: unexpected write addr=%0d data=%02h", v_ada, v_dina);
         end else begin
            mon_e = sb.pop_front();
            if (v_ada !== mon_e.a || v_dina !== mon_e.d) begin
               errors++;
               $display("FAIL vram_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                        v_ada, v_dina, mon_e.a, mon_e.d);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void push_wr(int a, logic [7:0] d);
      sb.push_back('{a: 10'(a), d: d});
      exp_img[a] = d;
   endfunction

   function automatic void push_clear();
      for (int i = 0; i < CELLS; i++) push_wr(i, 8'h20);
   endfunction

   function automatic void push_scroll();
      for (int i = 0; i < (ROWS - 1) * COLS; i++) push_wr(i, exp_img[i + COLS]);
      for (int i = (ROWS - 1) * COLS; i < CELLS; i++) push_wr(i, 8'h20);
   endfunction

   task automatic wait_idle(output int n);
      bit done;
      n    = 0;
      done = 1'b0;
      for (int k = 0; k < BOUND; k++) begin
         @(negedge PixelClk);
         if (!busy) begin
            done = 1'b1;
            break;
         end
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, BOUND);
      end
   endtask

   task automatic send_byte(input logic [7:0] d);
      bit got;
      @(posedge PixelClk); #1;
      ch_valid = 1'b1;
      ch_data  = d;
      got      = 1'b0;
      for (int k = 0; k < BOUND; k++) begin
         @(negedge PixelClk);
         if (ch_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL send_byte: ch_ready=%0b for byte %02h, required 1", ch_ready, d);
      end
      @(posedge PixelClk); #1;
      ch_valid = 1'b0;
   endtask

   task automatic check_cursor(input string name, input int col, input int row);
      checks++;
      if (cursor_col !== 6'(col) || cursor_row !== 5'(row)) begin
         errors++;
         $display("FAIL %s: cursor got (%0d,%0d), required (%0d,%0d)",
                  name, cursor_col, cursor_row, col, row);
      end
   endtask

   task automatic check_sb_empty(input string name);
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL %s: %0d required writes never seen, required 0", name, sb.size());
      end
   endtask

   task automatic do_clear(input string name);
      int n;
      push_clear();
      send_byte(8'h0C);
      wait_idle(n);
      checks++;
      if (n !== 1020) begin
         errors++;
         $display("FAIL %s: busy cycles %0d, required 1020", name, n);
      end
   endtask

   task automatic test_reset();
      int n;
      #1 nRST = 1'b0;
      #2;
      checks++;
      if ({busy, ch_ready, v_cea, v_wrea, v_ada, v_dina, cursor_col, cursor_row} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%0b rdy=%0b cea=%0b wrea=%0b ada=%0d dina=%02h, required all 0",
                  busy, ch_ready, v_cea, v_wrea, v_ada, v_dina);
      end
      repeat (3) @(posedge PixelClk);
      push_clear();
      #1 nRST = 1'b1;
      wait_idle(n);
      checks++;
      if (n !== 1020) begin
         errors++;
         $display("FAIL init_clear_busy: busy cycles %0d, required 1020", n);
      end
      check_cursor("init_clear_cursor", 0, 0);
      checks++;
      if (ch_ready !== 1'b1) begin
         errors++;
         $display("FAIL init_ready: ch_ready=%0b, required 1", ch_ready);
      end
      check_sb_empty("init_clear_writes");
   endtask

   task automatic test_put_single();
      push_wr(0, 8'h41);
      send_byte(8'h41);
      @(negedge PixelClk);
      checks++;
      if (ch_ready !== 1'b0) begin
         errors++;
         $display("FAIL put_ready_low: ch_ready=%0b, required 0", ch_ready);
      end
      @(negedge PixelClk);
      checks++;
      if (ch_ready !== 1'b1) begin
         errors++;
         $display("FAIL put_ready_back: ch_ready=%0b, required 1", ch_ready);
      end
      check_cursor("put_cursor", 1, 0);
      check_sb_empty("put_writes");
   endtask

   task automatic test_wrap();
      int n;
      do_clear("wrap_clear");
      for (int j = 0; j < 61; j++) begin
         push_wr(j, 8'h42);
         send_byte(8'h42);
      end
      wait_idle(n);
      check_cursor("wrap_cursor", 1, 1);
      check_sb_empty("wrap_writes");
   endtask

   task automatic test_scroll();
      int n;
      do_clear("scroll_clear");
      @(posedge PixelClk); #1 pre_load = 1'b1;
      @(posedge PixelClk); #1 pre_load = 1'b0;
      for (int i = 0; i < CELLS; i++) exp_img[i] = 8'(8'h30 + i / COLS);
      for (int j = 0; j < 16; j++) send_byte(8'h0A);
      for (int c = 0; c < 5; c++) begin
         push_wr(16 * COLS + c, 8'h40);
         send_byte(8'h40);
      end
      wait_idle(n);
      check_cursor("scroll_pre_cursor", 5, 16);
      push_scroll();
      send_byte(8'h0A);
      wait_idle(n);
      checks++;
      if (n !== 1980) begin
         errors++;
         $display("FAIL scroll_busy: busy cycles %0d, required 1980", n);
      end
      check_cursor("scroll_cursor", 0, 16);
      check_sb_empty("scroll_writes");
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            checks++;
            if (mem[r * COLS + c] !== ((r < 16) ? 8'(8'h31 + r) : 8'h20)) begin
               errors++;
               $display("FAIL scroll_content: row %0d col %0d holds %02h, required %02h",
                        r, c, mem[r * COLS + c], (r < 16) ? 8'(8'h31 + r) : 8'h20);
            end
         end
      end
   endtask

   task automatic test_bs_cr();
      int n;
      do_clear("bs_clear");
      send_byte(8'h0A);
      send_byte(8'h0A);
      for (int c = 0; c < 3; c++) begin
         push_wr(120 + c, 8'h43);
         send_byte(8'h43);
      end
      wait_idle(n);
      check_cursor("bs_pre_cursor", 3, 2);
      push_wr(122, 8'h20);
      send_byte(8'h08);
      wait_idle(n);
      check_cursor("bs_cursor", 2, 2);
      check_sb_empty("bs_write");
      send_byte(8'h0D);
      wait_idle(n);
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL cr_busy: busy cycles %0d, required 0", n);
      end
      check_cursor("cr_cursor", 0, 2);
      send_byte(8'h08);
      wait_idle(n);
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL bs_col0_busy: busy cycles %0d, required 0", n);
      end
      check_cursor("bs_col0_cursor", 0, 2);
   endtask

   task automatic test_clr_during_scroll();
      int n, cnt;
      for (int j = 0; j < 14; j++) send_byte(8'h0A);
      check_cursor("cds_pre_cursor", 0, 16);
      push_scroll();
      send_byte(8'h0A);
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge PixelClk);
         if (busy) cnt++;
      end
      @(posedge PixelClk); #1 clr_req = 1'b1;
      @(negedge PixelClk);
      if (busy) cnt++;
      @(posedge PixelClk); #1 clr_req = 1'b0;
      push_clear();
      wait_idle(n);
      cnt += n;
      checks++;
      if (cnt !== 1980) begin
         errors++;
         $display("FAIL cds_scroll_busy: busy cycles %0d, required 1980", cnt);
      end
      checks++;
      if (ch_ready !== 1'b0) begin
         errors++;
         $display("FAIL cds_pending_ready: ch_ready=%0b, required 0", ch_ready);
      end
      wait_idle(n);
      checks++;
      if (n !== 1020) begin
         errors++;
         $display("FAIL cds_clear_busy: busy cycles %0d, required 1020", n);
      end
      check_cursor("cds_cursor", 0, 0);
      check_sb_empty("cds_writes");
   endtask

   task automatic test_reset_mid_clear();
      int n;
      push_clear();
      send_byte(8'h0C);
      repeat (300) @(posedge PixelClk);
      #1 nRST = 1'b0;
      #1;
      checks++;
      if ({busy, ch_ready, v_cea, v_wrea, v_ada, v_dina, cursor_col, cursor_row} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: busy=%0b rdy=%0b cea=%0b wrea=%0b ada=%0d dina=%02h, required all 0",
                  busy, ch_ready, v_cea, v_wrea, v_ada, v_dina);
      end
      sb.delete();
      repeat (2) @(posedge PixelClk);
      push_clear();
      @(posedge PixelClk); #1 nRST = 1'b1;
      wait_idle(n);
      checks++;
      if (n !== 1020) begin
         errors++;
         $display("FAIL midreset_clear_busy: busy cycles %0d, required 1020", n);
      end
      check_cursor("midreset_cursor", 0, 0);
      checks++;
      if (ch_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_ready: ch_ready=%0b, required 1", ch_ready);
      end
      check_sb_empty("midreset_writes");
   endtask

   initial begin
      test_reset();
      test_put_single();
      test_wrap();
      test_scroll();
      test_bs_cr();
      test_clr_during_scroll();
      test_reset_mid_clear();
      repeat (2) @(posedge PixelClk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
